// File: rtl/imm_packer_pkg.sv
// Shared definitions for the immediate extender and its inverse, the immediate packer.
// Field positions are instruction bit indices of the immediate slices.
package core_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  localparam int I_IMM_LSB = 20;
  localparam int S_HI_LSB  = 25;
  localparam int S_LO_MSB  = 11;
  localparam int S_LO_LSB  = 7;
  localparam int B_B11_POS = 7;
  localparam int J_HI_LSB  = 21;
  localparam int J_B11_POS = 20;
  localparam int J_MID_LSB = 12;

endpackage

// File: rtl/imm_packer_if.sv
// Request/response bundle of the immediate packer; the packer sits on the slave side.
interface imm_packer_if;
  import core_pkg::*;

  logic        in_valid;
  logic        in_ready;
  immsrc_e     immsrc;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;

  modport master (
    output in_valid, immsrc, imm, base, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, immsrc, imm, base, out_ready,
    output in_ready, out_valid, instr, err
  );

endinterface

// File: rtl/imm_packer_range_chk.sv
// Flags an immediate that cannot be represented by the selected field layout:
// upper bits not a pure sign extension, or odd offset for branch/jump.
module imm_range_chk
  import core_pkg::*;
(
  input  logic [31:0] imm_i,
  input  immsrc_e     immsrc_i,
  output logic        err_o
);

  logic is_ok, b_ok, j_ok;

  assign is_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign b_ok  = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign j_ok  = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    err_o = 1'b0;
    case (immsrc_i)
      IMM_I, IMM_S: err_o = ~is_ok;
      IMM_B:        err_o = ~b_ok | imm_i[0];
      IMM_J:        err_o = ~j_ok | imm_i[0];
      default:      err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Inserts an immediate into an instruction skeleton (inverse of the immediate extender).
// Two-stage valid/ready pipe: S1 holds the request and range flag, S2 the packed word.
module imm_packer
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_packer_if.slave      bus,
  output logic [CNT_W-1:0] packed_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        s1_valid_q, s1_err_q;
  immsrc_e     s1_src_q;
  logic [31:0] s1_imm_q, s1_base_q;
  logic        s2_valid_q, err_q;
  logic [31:0] instr_q, packed_d;
  logic        s1_adv, s2_adv, accept, deliver, chk_err;
  logic [CNT_W-1:0] packed_cnt_q, packed_cnt_d, err_cnt_q, err_cnt_d;

  assign s2_adv  = ~s2_valid_q | bus.out_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign accept  = bus.in_valid & s1_adv;
  assign deliver = s2_valid_q & bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.instr     = instr_q;
  assign bus.err       = err_q;
  assign packed_cnt    = packed_cnt_q;
  assign err_cnt       = err_cnt_q;

  imm_range_chk u_range_chk (
    .imm_i    (bus.imm),
    .immsrc_i (bus.immsrc),
    .err_o    (chk_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_src_q   <= IMM_I;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (accept) begin
        s1_err_q  <= chk_err;
        s1_src_q  <= bus.immsrc;
        s1_imm_q  <= bus.imm;
        s1_base_q <= bus.base;
      end
    end
  end

  // Out-of-range items are still packed from the truncated bits.
  always_comb begin
    packed_d = s1_base_q;
    case (s1_src_q)
      IMM_I: packed_d[31:I_IMM_LSB] = s1_imm_q[11:0];
      IMM_S: begin
        packed_d[31:S_HI_LSB]       = s1_imm_q[11:5];
        packed_d[S_LO_MSB:S_LO_LSB] = s1_imm_q[4:0];
      end
      IMM_B: begin
        packed_d[31]                  = s1_imm_q[12];
        packed_d[30:S_HI_LSB]         = s1_imm_q[10:5];
        packed_d[S_LO_MSB:S_LO_LSB+1] = s1_imm_q[4:1];
        packed_d[B_B11_POS]           = s1_imm_q[11];
      end
      IMM_J: begin
        packed_d[31]                    = s1_imm_q[20];
        packed_d[30:J_HI_LSB]           = s1_imm_q[10:1];
        packed_d[J_B11_POS]             = s1_imm_q[11];
        packed_d[J_B11_POS-1:J_MID_LSB] = s1_imm_q[19:12];
      end
      default: packed_d = s1_base_q;
    endcase
  end

  // S2 only moves when the consumer can take its word, so stalls hold instr/err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      instr_q    <= '0;
      err_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        instr_q <= packed_d;
        err_q   <= s1_err_q;
      end
    end
  end

  always_comb begin
    packed_cnt_d = packed_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (deliver) begin
      if (packed_cnt_q != CNT_MAX) packed_cnt_d = packed_cnt_q + CNT_ONE;
      if (err_q && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      packed_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      packed_cnt_q <= packed_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Directed and random-round-trip bench for imm_packer; narrow counters expose saturation.
module tb_imm_packer;
  import core_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] packed_cnt, err_cnt;
  int               checks = 0;
  int               failures = 0;

  imm_packer_if bus ();

  imm_packer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .packed_cnt (packed_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference immediate extender, used to close the round trip.
  function automatic logic [31:0] ext(input logic [31:0] i, input logic [1:0] s);
    case (s)
      2'b00:   ext = {{20{i[31]}}, i[31:20]};
      2'b01:   ext = {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   ext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: ext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [1:0] s);
    case (s)
      2'b00:   keep_mask = 32'h000F_FFFF;
      2'b01:   keep_mask = 32'h01FF_F07F;
      2'b10:   keep_mask = 32'h01FF_F07F;
      default: keep_mask = 32'h0000_0FFF;
    endcase
  endfunction

  // Single item through an empty pipe, checking the two-cycle latency on the way.
  task automatic xfer(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                      output logic [31:0] instr, output logic err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.immsrc    = immsrc_e'(src);
    bus.imm       = imm;
    bus.base      = base;
    #1 chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_c1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("latency_c2", 32'(bus.out_valid), 32'd1);
    instr = bus.instr;
    err   = bus.err;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs [6] = '{
    '{2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0},
    '{2'b01, 32'hFFFF_FFFC, 32'h0000_0023, 32'hFE00_0E23, 1'b0},
    '{2'b10, 32'h0000_0010, 32'h0000_0063, 32'h0000_0863, 1'b0},
    '{2'b11, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0},
    '{2'b00, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1},
    '{2'b10, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins, held, r, imm_v, base_v;
    logic        e, was_stall;
    logic [1:0]  src_v;
    logic [31:0] s_imm [8];
    logic [31:0] s_exp [8];
    int          sent, rcvd, cyc;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.immsrc    = IMM_I;
    bus.imm       = '0;
    bus.base      = '0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_packed_cnt", 32'(packed_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      xfer(vecs[i].src, vecs[i].imm, vecs[i].base, ins, e);
      chk($sformatf("vec%0d_instr", i), ins, vecs[i].exp);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
    end
    @(negedge clk);
    chk("dir_packed_cnt", 32'(packed_cnt), 32'd6);
    chk("dir_err_cnt", 32'(err_cnt), 32'd2);

    for (int i = 0; i < 8; i++) begin
      s_imm[i] = 32'(i * 37) - 32'd100;
      s_exp[i] = {s_imm[i][11:0], 20'h0_0013};
    end
    sent = 0;
    rcvd = 0;
    cyc = 0;
    was_stall = 1'b0;
    held = '0;
    while (rcvd < 8 && cyc < 60) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      bus.in_valid  = (sent < 8);
      bus.immsrc    = IMM_I;
      bus.base      = 32'h0000_0013;
      bus.imm       = (sent < 8) ? s_imm[sent] : 32'd0;
      #1;
      if (was_stall) chk("stall_hold", bus.instr, held);
      if (cyc == 3) chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
      if (cyc == 5) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      was_stall = bus.out_valid && !bus.out_ready;
      held = bus.instr;
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("stream%0d", rcvd), bus.instr, s_exp[rcvd]);
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(rcvd), 32'd8);
    @(negedge clk);
    chk("stream_packed_cnt", 32'(packed_cnt), 32'd14);
    chk("stream_drained", 32'(bus.out_valid), 32'd0);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.imm       = 32'd5;
    @(negedge clk);
    bus.imm = 32'd6;
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_packed_cnt", 32'(packed_cnt), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("mid_rst_no_ghost", 32'(bus.out_valid), 32'd0);

    for (int n = 0; n < 20; n++) begin
      r      = $urandom;
      base_v = $urandom;
      src_v  = 2'($urandom_range(0, 3));
      case (src_v)
        2'b00, 2'b01: imm_v = {{20{r[11]}}, r[11:0]};
        2'b10:        imm_v = {{19{r[12]}}, r[12:1], 1'b0};
        default:      imm_v = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      xfer(src_v, imm_v, base_v, ins, e);
      chk("rt_err", 32'(e), 32'd0);
      if (!e) chk($sformatf("rt_imm%0d", n), ext(ins, src_v), imm_v);
      chk($sformatf("rt_base%0d", n), ins & keep_mask(src_v), base_v & keep_mask(src_v));
    end
    @(negedge clk);
    chk("sat_packed_cnt", 32'(packed_cnt), 32'd15);
    chk("sat_err_cnt", 32'(err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
